alu32_arbiter: RTL and testbench
================================

ALU32_ARBITER -- requirements
Module: alu32_arbiter

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits and exactly two requesters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  3  ALU control code for requester 0, passed unmodified to the alu32 add[2:0] input.
REQ-007 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meanings for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_out  output  32  ALU result.
REQ-013 rsp_cout, rsp_zero, rsp_ovf  output  1 each  registered alu32 cout, zout and overflow.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL instantiate exactly one alu32 and time-share it between both requesters.
REQ-016 The FSM SHALL have states IDLE, EXEC and RESP, and no others.
REQ-017 In IDLE with at least one reqN_valid high, the block SHALL assert reqN_ready for exactly one granted port in that cycle (combinational from valid and the pointer).
- On the same edge it SHALL latch that port's op, a and b into operand registers and enter EXEC.
REQ-018 Arbitration SHALL be round-robin.
- With both valid, the port not served last wins.
- With one valid, that port wins regardless of the pointer.
REQ-019 The last-served pointer SHALL update only on the IDLE grant edge.
REQ-020 req0_ready and req1_ready SHALL both be low in EXEC and RESP, and never high together.
REQ-021 EXEC SHALL last exactly one cycle.
- alu32 is driven from the operand registers.
- Its out/cout/zout/overflow are captured into the rsp_* registers, the grant index into rsp_id, and the FSM moves to RESP.
REQ-022 In RESP, rsp_valid SHALL be high.
- rsp_* and rsp_id SHALL hold stable until the cycle rsp_valid and rsp_ready are both high.
- On that edge the FSM SHALL return to IDLE.
REQ-023 rsp_valid SHALL be low in IDLE and EXEC.
REQ-024 Latency SHALL be: grant at edge N, result captured at edge N+1, rsp_valid high from edge N+1 onward.
REQ-025 Minimum spacing SHALL be one grant per three cycles (grant, EXEC, RESP handshake); no grant is issued in the cycle of the RESP handshake.
REQ-026 rsp_ready high in IDLE or EXEC SHALL be ignored.
REQ-027 A requester dropping reqN_valid before being granted SHALL lose nothing and cause no state change.
REQ-028 Operand inputs SHALL be sampled only on the grant edge; later changes SHALL NOT affect the in-flight result.
REQ-029 Arithmetic SHALL be exactly alu32's; the block SHALL NOT alter, extend or saturate results or flags.

Reset
REQ-030 While reset is high, asynchronously:
- state = IDLE, pointer = 1 (so port 0 wins first contention);
- rsp_valid = 0, rsp_id = 0, rsp_out = 0, rsp_cout = rsp_zero = rsp_ovf = 0;
- busy = 0, both reqN_ready = 0.
REQ-031 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-032 The first grant SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-033 Single op:
- Stimulus: req0 ADD code, a=0x00000005, b=0x00000003, rsp_ready=1.
- Response: req0_ready one cycle; rsp_valid one edge later with rsp_out=0x00000008, rsp_id=0, rsp_zero=0.
REQ-034 Contention:
- Stimulus: both valid continuously from reset, rsp_ready=1.
- Response: grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; grants 3 cycles apart.
REQ-035 Backpressure:
- Stimulus: rsp_ready=0 for 5 cycles in RESP.
- Response: rsp_* stable, both readys low, busy=1; handshake on first rsp_ready=1, then IDLE.
REQ-036 Flags:
- Stimulus: ADD a=0x7FFFFFFF, b=0x00000001.
- Response: rsp_out=0x80000000, rsp_ovf=1, rsp_cout=0.
- Stimulus: ADD a=0xFFFFFFFF, b=0x00000001.
- Response: rsp_out=0, rsp_cout=1, rsp_zero=1.
REQ-037 Reset mid-op:
- Stimulus: assert reset during EXEC.
- Response: rsp_valid never rises for that op; all outputs at REQ-030 values immediately.
REQ-038 Operand stability: change req0_a in EXEC -> result reflects the value sampled at grant.

Source files
------------

// File: rtl/alu32_arbiter.sv
// Two-requester round-robin front end time-sharing one 32-bit ALU.
// Grant in IDLE, one EXEC cycle, then hold the registered result until the consumer takes it.

module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  add,
  output logic [31:0] out,
  output logic        cout,
  output logic        zout,
  output logic        overflow
);
  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        arith_ovf;

  always_comb begin
    sub       = (add == 3'b110) || (add == 3'b111);
    b_eff     = sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub};
    arith_ovf = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    out       = '0;
    cout      = 1'b0;
    overflow  = 1'b0;
    case (add)
      3'b000: out = a & b;
      3'b001: out = a | b;
      3'b010, 3'b110: begin
        out      = sum[31:0];
        cout     = sum[32];
        overflow = arith_ovf;
      end
      3'b011: out = a ^ b;
      3'b100: out = ~(a | b);
      3'b101: out = a << b[4:0];
      // Signed less-than: sign of the difference corrected by overflow.
      3'b111: out = {31'b0, sum[31] ^ arith_ovf};
      default: out = '0;
    endcase
    zout = (out == 32'b0);
  end
endmodule

module alu32_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_out,
  output logic        rsp_cout,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        busy
);
  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q;
  logic        gnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        grant, grant_valid;
  logic [31:0] alu_out;
  logic        alu_cout, alu_zout, alu_ovf;

  alu32 u_alu (
    .a       (a_q),
    .b       (b_q),
    .add     (op_q),
    .out     (alu_out),
    .cout    (alu_cout),
    .zout    (alu_zout),
    .overflow(alu_ovf)
  );

  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant       = 1'b0;
    // Contention goes to the port not served last; a lone requester always wins.
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
    case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          grant_valid = 1'b1;
          state_d     = StExec;
        end
      end
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign req0_ready = grant_valid && !grant && !reset;
  assign req1_ready = grant_valid && grant && !reset;
  assign rsp_valid  = (state_q == StResp);
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_id   <= 1'b0;
      rsp_out  <= '0;
      rsp_cout <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        last_q <= grant;
        gnt_q  <= grant;
        op_q   <= grant ? req1_op : req0_op;
        a_q    <= grant ? req1_a : req0_a;
        b_q    <= grant ? req1_b : req0_b;
      end
      if (state_q == StExec) begin
        rsp_id   <= gnt_q;
        rsp_out  <= alu_out;
        rsp_cout <= alu_cout;
        rsp_zero <= alu_zout;
        rsp_ovf  <= alu_ovf;
      end
    end
  end
endmodule

// File: tb/tb_alu32_arbiter.sv
// Randomized and directed bench for alu32_arbiter against a transaction-level reference.
`timescale 1ns/1ps
module tb_alu32_arbiter;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpSub = 3'b110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [31:0] rsp_out;
  logic        rsp_cout, rsp_zero, rsp_ovf, busy;

  int errors = 0;
  int checks = 0;
  logic rr_last;

  wire [36:0] rsp_vec = {rsp_valid, rsp_id, rsp_cout, rsp_zero, rsp_ovf, rsp_out};
  wire [3:0]  ctl_vec = {busy, rsp_valid, req1_ready, req0_ready};

  always #5 clk = ~clk;

  alu32_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference result vector {valid, id, cout, zero, ovf, out} from plain arithmetic.
  task automatic alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic id, output logic [36:0] v);
    logic [31:0] o;
    logic [63:0] u;
    logic        c, f;
    longint      sa, sb, ss;
    sa = $signed(a);
    sb = $signed(b);
    c = 1'b0;
    f = 1'b0;
    case (op)
      3'b000: o = a & b;
      3'b001: o = a | b;
      3'b010: begin
        u = {32'b0, a} + {32'b0, b};
        o = u[31:0];
        c = u[32];
        ss = sa + sb;
        f = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'b011: o = a ^ b;
      3'b100: o = ~(a | b);
      3'b101: o = a << b[4:0];
      3'b110: begin
        o = a - b;
        c = (a >= b);
        ss = sa - sb;
        f = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      default: o = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    v = {1'b1, id, c, (o == 32'b0), f, o};
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (ctl_vec !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl got %b want %b", ctl_vec, 4'b0000);
    end
    checks++;
    if (rsp_vec !== 37'b0) begin
      errors++;
      $display("FAIL reset_rsp got %h want %h", rsp_vec, 37'b0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    rr_last = 1'b1;
    #1;
    checks++;
    if (ctl_vec !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got %b want %b", ctl_vec, 4'b0001);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single_op();
    logic [36:0] exp_v;
    req0_valid = 1'b1; req0_op = OpAdd; req0_a = 32'h5; req0_b = 32'h3; rsp_ready = 1'b1;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8};
    #1;
    checks++;
    if (ctl_vec !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got %b want %b", ctl_vec, 4'b0001);
    end
    rr_last = 1'b0;
    tick();
    req0_valid = 1'b0;
    checks++;
    if (ctl_vec !== 4'b1000) begin
      errors++;
      $display("FAIL single_exec got %b want %b", ctl_vec, 4'b1000);
    end
    tick();
    checks++;
    if (rsp_vec !== exp_v) begin
      errors++;
      $display("FAIL single_rsp got %h want %h", rsp_vec, exp_v);
    end
    tick();
    checks++;
    if (ctl_vec !== 4'b0000) begin
      errors++;
      $display("FAIL single_back_idle got %b want %b", ctl_vec, 4'b0000);
    end
  endtask

  task automatic test_contention();
    logic exp_id;
    req0_op = OpAdd; req0_a = 32'd100; req0_b = 32'd0;
    req1_op = OpAdd; req1_a = 32'd200; req1_b = 32'd0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    reset = 1'b1;
    #1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      exp_id = ((c / 3) % 2) == 1;
      if (c % 3 == 0) begin
        checks++;
        if ({req1_ready, req0_ready} !== {exp_id, !exp_id}) begin
          errors++;
          $display("FAIL contention_grant c=%0d got %b want %b", c,
                   {req1_ready, req0_ready}, {exp_id, !exp_id});
        end
      end else if (c % 3 == 2) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, exp_id, exp_id ? 32'd200 : 32'd100}) begin
          errors++;
          $display("FAIL contention_rsp c=%0d got %b/%0d/%0d want 1/%0d/%0d", c, rsp_valid,
                   rsp_id, rsp_out, exp_id, exp_id ? 200 : 100);
        end
      end else begin
        checks++;
        if (ctl_vec !== 4'b1000) begin
          errors++;
          $display("FAIL contention_exec c=%0d got %b want %b", c, ctl_vec, 4'b1000);
        end
      end
      tick();
    end
    rr_last = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_flags();
    logic [2:0]  ops  [4] = '{OpAdd, OpAdd, OpSub, OpSub};
    logic [31:0] as   [4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000};
    logic [31:0] bs   [4] = '{32'h00000001, 32'h00000001, 32'h00000005, 32'h00000001};
    logic [2:0]  flg  [4] = '{3'b001, 3'b110, 3'b110, 3'b101};  // {cout, zero, ovf}
    logic [31:0] outs [4] = '{32'h80000000, 32'h0, 32'h0, 32'h7FFFFFFF};
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1; req1_op = ops[i]; req1_a = as[i]; req1_b = bs[i];
      tick();
      req1_valid = 1'b0;
      rr_last = 1'b1;
      tick();
      checks++;
      if (rsp_vec !== {2'b11, flg[i], outs[i]}) begin
        errors++;
        $display("FAIL flags_%0d got %h want %h", i, rsp_vec, {2'b11, flg[i], outs[i]});
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] exp_v;
    req0_valid = 1'b1; req0_op = OpXor; req0_a = $urandom; req0_b = $urandom;
    alu_ref(OpXor, req0_a, req0_b, 1'b0, exp_v);
    rsp_ready = 1'b0;
    tick();
    rr_last = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({ctl_vec, rsp_vec} !== {4'b1100, exp_v}) begin
        errors++;
        $display("FAIL backpressure_hold i=%0d got %b/%h want %b/%h", i, ctl_vec, rsp_vec,
                 4'b1100, exp_v);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (ctl_vec !== 4'b1100) begin
      errors++;
      $display("FAIL backpressure_handshake got %b want %b", ctl_vec, 4'b1100);
    end
    tick();
    checks++;
    if (ctl_vec !== 4'b0010) begin
      errors++;
      $display("FAIL backpressure_idle got %b want %b", ctl_vec, 4'b0010);
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    req1_valid = 1'b1; req1_op = OpAdd; req1_a = 32'd1; req1_b = 32'd2; rsp_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({ctl_vec, rsp_vec} !== 41'b0) begin
      errors++;
      $display("FAIL midop_reset got %b/%h want all zero", ctl_vec, rsp_vec);
    end
    tick();
    reset = 1'b0;
    rr_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ctl_vec !== 4'b0000) begin
        errors++;
        $display("FAIL midop_no_rsp i=%0d got %b want %b", i, ctl_vec, 4'b0000);
      end
    end
  endtask

  task automatic test_operand_stability();
    logic [36:0] exp_v;
    req0_valid = 1'b1; req0_op = OpAdd; req0_a = 32'd10; req0_b = 32'd20; rsp_ready = 1'b1;
    alu_ref(OpAdd, 32'd10, 32'd20, 1'b0, exp_v);
    tick();
    rr_last = 1'b0;
    req0_valid = 1'b0;
    req0_a = 32'd999;
    req0_b = 32'hFFFF0000;
    tick();
    checks++;
    if (rsp_vec !== exp_v) begin
      errors++;
      $display("FAIL operand_stability got %h want %h", rsp_vec, exp_v);
    end
    tick();
  endtask

  task automatic test_random();
    logic        v0, v1, win;
    logic [36:0] exp_v;
    int          hold;
    for (int n = 0; n < 60; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      req0_valid = v0; req1_valid = v1;
      req0_op = 3'($urandom); req0_a = $urandom; req0_b = $urandom;
      req1_op = 3'($urandom); req1_a = $urandom; req1_b = $urandom;
      if ($urandom_range(0, 3) == 0) req0_b = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) req1_a = 32'h80000000;
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      win = (v0 && v1) ? !rr_last : v1;
      checks++;
      if ({req1_ready, req0_ready} !== ((v0 || v1) ? {win, !win} : 2'b00)) begin
        errors++;
        $display("FAIL random_grant n=%0d v=%b%b got %b want %b", n, v1, v0,
                 {req1_ready, req0_ready}, (v0 || v1) ? {win, !win} : 2'b00);
      end
      if (!(v0 || v1)) begin
        tick();
        continue;
      end
      if (win) alu_ref(req1_op, req1_a, req1_b, 1'b1, exp_v);
      else     alu_ref(req0_op, req0_a, req0_b, 1'b0, exp_v);
      rr_last = win;
      tick();
      req0_a = $urandom; req1_b = $urandom;
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'b0;
      tick();
      hold = $urandom_range(0, 3);
      for (int k = 0; k <= hold; k++) begin
        if (k == hold) rsp_ready = 1'b1;
        #1;
        checks++;
        if ({ctl_vec, rsp_vec} !== {4'b1100, exp_v}) begin
          errors++;
          $display("FAIL random_rsp n=%0d k=%0d got %b/%h want %b/%h", n, k, ctl_vec, rsp_vec,
                   4'b1100, exp_v);
        end
        tick();
      end
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL random_idle n=%0d got %b want %b", n, {busy, rsp_valid}, 2'b00);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rr_last = 1'b1;
    #3;
    test_reset();
    test_single_op();
    test_contention();
    test_flags();
    test_backpressure();
    test_reset_mid_op();
    test_operand_stability();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
